seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexed scan controller for an NUM_DIGITS-digit common-segment seven-segment display. Accepts a BCD number with sign and error flags, formats each digit into a 4-bit display code (0-9, A = dash, E = error, F = blank), and cycles one active digit at a time at a prescaled refresh rate. It drives the shared segment bus through one Seven_Segment_Decoder instance. New values are committed only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- NUM_DIGITS, 4: number of digit positions, 2..8.
- TICK_DIV, 50000: clk cycles per digit slot, ≥ 2.
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  one-cycle strobe; samples load_bcd, load_neg and load_err.
- load_bcd  in  4*NUM_DIGITS  BCD digits; digit 0 (least significant) is at [3:0].
- load_neg  in  1  value is negative.
- load_err  in  1  force the error display.
- pending  out  1  a loaded value waits for the next frame boundary.
- frame_start  out  1  one-cycle pulse on the cycle that digit 0 becomes active.
- digit_en  out  NUM_DIGITS  one-hot active-high digit enable.
- code  out  4  registered display code for the active digit.
- seg  out  7  gfedcba, active high, decoded combinationally from code.

## Operation
- Prescaler counts 0..TICK_DIV-1. At the terminal count it wraps and raises an internal tick.
- On each tick the digit index advances by 1, wrapping from NUM_DIGITS-1 to 0.
- digit_en is set to one-hot(index) and code to disp[index], both in the same cycle.
- Load handling:
  - A load_valid write goes to the pending register and sets pending. The latest load wins and silently overwrites any earlier pending value.
  - Commit happens on a tick where the index wraps to 0. The formatted pending value is copied into disp, pending clears, and frame_start pulses together with the new digit_en and code.
  - If load_valid falls on a commit tick, the incoming value is committed directly and pending stays 0.
- Formatting, applied at commit:
  - The error form is produced when load_err = 1 or any load_bcd nibble exceeds 9.
  - Error form: position NUM_DIGITS-1 = E, all other positions = F.
  - Leading positions above the highest nonzero digit are blanked (F). Digit 0 is never blanked, so a zero value shows as one "0".
  - If load_neg = 1, a dash (A) is placed in the blank position immediately left of the most significant shown digit.
  - If there is no such blank position (digit NUM_DIGITS-1 is nonzero), the error form is produced instead.
  - -0 is shown as "-0".

## Timing
- Reset values:
  - prescaler 0, index 0, digit_en = 1 (digit 0)
  - disp all F, so code = F and seg = 0000000
  - pending register all F with flags clear; pending 0; frame_start 0
- Each digit stays active for exactly TICK_DIV cycles, and a full frame lasts NUM_DIGITS*TICK_DIV cycles.
- Load-to-display latency runs from load_valid to the next index wrap: at least 1 cycle and at most NUM_DIGITS*TICK_DIV cycles.
- pending rises in the cycle after the load_valid edge.
- rst asserted mid-frame or mid-pending returns every register to its reset value on that edge. Loads in the reset cycle are dropped.
- seg has no register stage, so seg and digit_en change in the same cycle.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN
  - Defined: leading-zero blanking and dash placement as described under Operation.
  - Undefined: all digits are shown, including leading zeros. A negative value puts the dash in position NUM_DIGITS-1, which requires digit NUM_DIGITS-1 = 0; otherwise the error form is produced.

## Structure
- Shared package:
  - display-code constants CODE_DASH = 4'hA, CODE_ERR = 4'hE, CODE_BLANK = 4'hF
  - a typedef for the 4-bit display code
- Sub-module: Seven_Segment_Decoder, instantiated once with code → seg.
- Formatting is a combinational function inside this block. There is no separate formatter module.

## Test plan
All scenarios use NUM_DIGITS = 4 and TICK_DIV = 4.
- Reset: code = F and seg = 0 on all digits; digit_en steps 0001 → 0010 → 0100 → 1000 → 0001 every 4 cycles; frame_start pulses every 16 cycles.
- Load bcd 0x0042 with the macro defined: after the next frame_start, digits 0..3 show codes 2, 4, F, F. With the macro undefined they show 2, 4, 0, 0.
- Load 0x0042 with load_neg: codes 2, 4, A, F. Load 0x1234 with load_neg: codes F, F, F, E. Load 0x00A1 (invalid nibble): codes F, F, F, E.
- Overwrite: load 0x0001 and then 0x0009 within one frame. The display shows only 9; pending stays 1 from the first load until frame_start, then drops to 0.
- Load collides with commit: load_valid 0x0005 in the wrap cycle. code = 5 in that same cycle and pending stays 0.
- Reset mid-frame with a pending load: all outputs return to their reset values and the value that was pending is never displayed.

Source files
------------

// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared display-code definitions for the seven-segment scan controller and its decoder.
package seven_segment_scan_controller_pkg;

  typedef logic [3:0] disp_code_t;

  localparam disp_code_t CODE_DASH  = 4'hA;
  localparam disp_code_t CODE_ERR   = 4'hE;
  localparam disp_code_t CODE_BLANK = 4'hF;

endpackage

// File: rtl/seven_segment_scan_controller_decoder.sv
// Display code to gfedcba segment pattern (active high); dash lights g only, blank lights nothing.
module Seven_Segment_Decoder
  import seven_segment_scan_controller_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (code)
      4'h0:       seg = 7'h3F;
      4'h1:       seg = 7'h06;
      4'h2:       seg = 7'h5B;
      4'h3:       seg = 7'h4F;
      4'h4:       seg = 7'h66;
      4'h5:       seg = 7'h6D;
      4'h6:       seg = 7'h7D;
      4'h7:       seg = 7'h07;
      4'h8:       seg = 7'h7F;
      4'h9:       seg = 7'h6F;
      CODE_DASH:  seg = 7'h40;
      CODE_ERR:   seg = 7'h79;
      default:    seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value commits.
// SEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking with a floating minus sign.
module seven_segment_scan_controller
  import seven_segment_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic                    load_neg,
  input  logic                    load_err,
  output logic                    pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              code,
  output logic [6:0]              seg
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] prescaler;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] next_idx;
  logic [W-1:0]     disp;
  logic [W-1:0]     disp_next;
  logic [W-1:0]     formatted;
  logic [W-1:0]     pend_bcd;
  logic             pend_neg;
  logic             pend_err;
  logic             tick;
  logic             wrap;
  logic             commit;

  function automatic logic [W-1:0] format_value(input logic [W-1:0] bcd,
                                                input logic neg, input logic err);
    logic [W-1:0] r;
    logic         bad;
    bad = err;
    r   = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bcd[4*i +: 4] != 4'd0) msd = i;
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (i > msd) r[4*i +: 4] = CODE_BLANK;
      end
      if (neg) begin
        if (msd == NUM_DIGITS - 1) bad = 1'b1;
        else r[4*(msd+1) +: 4] = CODE_DASH;
      end
    end
`else
    if (neg) begin
      if (bcd[W-1 -: 4] != 4'd0) bad = 1'b1;
      else r[W-1 -: 4] = CODE_DASH;
    end
`endif
    if (bad) begin
      r          = {W{1'b1}};
      r[W-1 -: 4] = CODE_ERR;
    end
    return r;
  endfunction

  always_comb begin
    tick     = (prescaler == PRE_W'(TICK_DIV - 1));
    wrap     = (index == IDX_W'(NUM_DIGITS - 1));
    next_idx = wrap ? '0 : index + 1'b1;
    // A load arriving on the wrap tick bypasses the pending register.
    commit   = tick && wrap && (pending || load_valid);
    if (load_valid) formatted = format_value(load_bcd, load_neg, load_err);
    else            formatted = format_value(pend_bcd, pend_neg, pend_err);
    disp_next = commit ? formatted : disp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      index       <= '0;
      digit_en    <= NUM_DIGITS'(1);
      code        <= CODE_BLANK;
      disp        <= {W{1'b1}};
      pend_bcd    <= {W{1'b1}};
      pend_neg    <= 1'b0;
      pend_err    <= 1'b0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      prescaler   <= tick ? '0 : prescaler + 1'b1;
      if (load_valid && !commit) begin
        pend_bcd <= load_bcd;
        pend_neg <= load_neg;
        pend_err <= load_err;
        pending  <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      if (tick) begin
        index       <= next_idx;
        digit_en    <= NUM_DIGITS'(1) << next_idx;
        code        <= disp_next[4*next_idx +: 4];
        frame_start <= wrap;
      end
      disp <= disp_next;
    end
  end

  Seven_Segment_Decoder u_decoder (
    .code (code),
    .seg  (seg)
  );

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller with NUM_DIGITS = 4 and TICK_DIV = 4.
module tb_seven_segment_scan_controller;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_bcd;
  logic        load_neg;
  logic        load_err;
  logic        pending;
  logic        frame_start;
  logic [3:0]  digit_en;
  logic [3:0]  code;
  logic [6:0]  seg;

  int n_cmp  = 0;
  int n_fail = 0;

  seven_segment_scan_controller #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_bcd    (load_bcd),
    .load_neg    (load_neg),
    .load_err    (load_err),
    .pending     (pending),
    .frame_start (frame_start),
    .digit_en    (digit_en),
    .code        (code),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h40;
      4'hE: return 7'h79;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame_start(input string tag);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_start && n < 40);
    check({tag, " frame_start"}, 32'(frame_start), 32'd1);
  endtask

  // Call at the frame_start cycle; walks all four digit slots.
  task automatic show_frame(input string tag, input logic [15:0] exp);
    logic [3:0] c;
    logic [3:0] en;
    for (int d = 0; d < 4; d++) begin
      c  = exp[4*d +: 4];
      en = 4'b0001 << d;
      check($sformatf("%s code d%0d", tag, d), 32'(code), 32'(c));
      check($sformatf("%s seg d%0d", tag, d), 32'(seg), 32'(seg_of(c)));
      check($sformatf("%s digit_en d%0d", tag, d), 32'(digit_en), 32'(en));
      if (d < 3) step(4);
    end
  endtask

  task automatic do_load(input logic [15:0] bcd, input logic neg, input logic err);
    load_valid = 1'b1;
    load_bcd   = bcd;
    load_neg   = neg;
    load_err   = err;
    step(1);
    load_valid = 1'b0;
  endtask

  task automatic load_and_show(input string tag, input logic [15:0] bcd, input logic neg,
                               input logic err, input logic [15:0] exp);
    do_load(bcd, neg, err);
    check({tag, " pending set"}, 32'(pending), 32'd1);
    wait_frame_start(tag);
    check({tag, " pending clear"}, 32'(pending), 32'd0);
    show_frame(tag, exp);
  endtask

  initial begin
    logic [3:0] en;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_bcd   = 16'h0000;
    load_neg   = 1'b0;
    load_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset code", 32'(code), 32'hF);
    check("reset seg", 32'(seg), 32'h0);
    check("reset pending", 32'(pending), 32'd0);
    for (int k = 0; k <= 16; k++) begin
      en = 4'b0001 << ((k / 4) % 4);
      check($sformatf("scan digit_en k%0d", k), 32'(digit_en), 32'(en));
      check($sformatf("scan frame_start k%0d", k), 32'(frame_start), 32'(k == 16));
      if (k % 4 == 0) check($sformatf("scan code k%0d", k), 32'(code), 32'hF);
      if (k < 16) step(1);
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    load_and_show("pos42", 16'h0042, 1'b0, 1'b0, 16'hFF42);
    load_and_show("neg42", 16'h0042, 1'b1, 1'b0, 16'hFA42);
    load_and_show("neg0", 16'h0000, 1'b1, 1'b0, 16'hFFA0);
`else
    load_and_show("pos42", 16'h0042, 1'b0, 1'b0, 16'h0042);
    load_and_show("neg42", 16'h0042, 1'b1, 1'b0, 16'hA042);
    load_and_show("neg0", 16'h0000, 1'b1, 1'b0, 16'hA000);
`endif
    load_and_show("neg1234", 16'h1234, 1'b1, 1'b0, 16'hEFFF);
    load_and_show("badnib", 16'h00A1, 1'b0, 1'b0, 16'hEFFF);
    load_and_show("errflag", 16'h0007, 1'b0, 1'b1, 16'hEFFF);

    // Two loads inside one frame: only the second may ever reach the display.
    wait_frame_start("ovw sync");
    do_load(16'h0001, 1'b0, 1'b0);
    check("ovw pending first", 32'(pending), 32'd1);
    step(5);
    do_load(16'h0009, 1'b0, 1'b0);
    check("ovw pending second", 32'(pending), 32'd1);
    step(4);
    check("ovw pending held", 32'(pending), 32'd1);
    wait_frame_start("ovw");
    check("ovw pending clear", 32'(pending), 32'd0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    show_frame("ovw", 16'hFFF9);
`else
    show_frame("ovw", 16'h0009);
`endif

    // show_frame leaves us in frame cycle 12; three more edges reach the wrap cycle.
    step(3);
    do_load(16'h0005, 1'b0, 1'b0);
    check("coll frame_start", 32'(frame_start), 32'd1);
    check("coll code", 32'(code), 32'h5);
    check("coll pending", 32'(pending), 32'd0);
    check("coll digit_en", 32'(digit_en), 32'h1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    show_frame("coll", 16'hFFF5);
`else
    show_frame("coll", 16'h0005);
`endif

    // Reset with a value pending and a load on the reset edge itself.
    do_load(16'h0007, 1'b0, 1'b0);
    check("rstmid pending set", 32'(pending), 32'd1);
    step(1);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_bcd   = 16'h0008;
    step(1);
    rst        = 1'b0;
    load_valid = 1'b0;
    check("rstmid code", 32'(code), 32'hF);
    check("rstmid seg", 32'(seg), 32'h0);
    check("rstmid digit_en", 32'(digit_en), 32'h1);
    check("rstmid pending", 32'(pending), 32'd0);
    check("rstmid frame_start", 32'(frame_start), 32'd0);
    wait_frame_start("rstmid");
    check("rstmid pending after", 32'(pending), 32'd0);
    show_frame("rstmid", 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
